// File: rtl/mic1_exec_ctrl_if.sv
// Front-panel / datapath bundle for the MIC-1 execution controller.
//   master : front panel + MIC-1 side. Drives the debounced button levels and
//            cpu_halt, and consumes the clock-enable, CPU reset, counter and LEDs.
//   slave  : the controller (mic1_exec_ctrl).
//
// Handshake: there is no valid/ready pair on this bundle. The buttons are
// plain levels, and the controller turns each 0->1 transition into a
// one-cycle press. cpu_ce is a one-cycle qualifier: the datapath executes
// one microinstruction in every cycle where it is high.
//
// dbg_state exposes the controller FSM encoding:
//   0 IDLE, 1 RUN, 2 STEP, 3 HALTED, 4 CPURST.
interface mic1_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             btn_run;
  logic             btn_stop;
  logic             btn_step;
  logic             btn_rst;
  logic             cpu_halt;
  logic             cpu_ce;
  logic             cpu_reset;
  logic [CNT_W-1:0] ucode_cnt;
  logic             led_idle;
  logic             led_run;
  logic             led_halt;
  logic [3:0]       led_step;
  logic [2:0]       dbg_state;

  modport master (
    output btn_run, btn_stop, btn_step, btn_rst, cpu_halt,
    input  cpu_ce, cpu_reset, ucode_cnt, led_idle, led_run, led_halt,
           led_step, dbg_state
  );

  modport slave (
    input  btn_run, btn_stop, btn_step, btn_rst, cpu_halt,
    output cpu_ce, cpu_reset, ucode_cnt, led_idle, led_run, led_halt,
           led_step, dbg_state
  );
endinterface

// File: rtl/mic1_exec_ctrl.sv
// MIC-1 execution controller.
// Turns debounced front-panel button levels into press events and drives the
// MIC-1 datapath with a per-microinstruction clock enable (cpu_ce) and a
// multi-cycle synchronous CPU reset (cpu_reset). Counts executed
// microinstructions, stops on a CPU halt request, and drives the status LEDs.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high block reset
//   bus    : mic1_exec_ctrl_if.slave (buttons, cpu_halt in; cpu_ce,
//            cpu_reset, ucode_cnt, LEDs, dbg_state out)
//
// Parameters:
//   RUN_DIV    : clk cycles per cpu_ce pulse in RUN (>= 1)
//   RST_CYCLES : cycles cpu_reset is held after a reset command (>= 1)
//   CNT_W      : microinstruction counter width (>= 4, feeds led_step)
module mic1_exec_ctrl #(
  parameter int RUN_DIV    = 4,
  parameter int RST_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  mic1_exec_ctrl_if.slave     bus
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_CPURST = 3'd4
  } state_t;

  // Button vector layout: [3]=rst, [2]=stop, [1]=step, [0]=run
  logic [3:0]       btn;
  logic [3:0]       prev_q,    prev_d;
  logic [3:0]       press_q,   press_d;
  state_t           state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic p_rst, p_stop, p_step, p_run;
  logic div_last;
  logic enter_rst;
  logic ce;
  logic cpu_rst;

  assign btn = {bus.btn_rst, bus.btn_stop, bus.btn_step, bus.btn_run};

  // Presses are registered, so a level first seen at edge N acts at edge N+1.
  // prev resets to all ones: a button held through reset must be released
  // and pressed again before it counts.
  always_comb begin
    prev_d  = btn;
    press_d = btn & ~prev_q;
  end

  // Only the highest-priority press in a cycle survives: rst > stop > step > run.
  assign p_rst  = press_q[3];
  assign p_stop = press_q[2] & ~press_q[3];
  assign p_step = press_q[1] & ~(|press_q[3:2]);
  assign p_run  = press_q[0] & ~(|press_q[3:1]);

  assign div_last = (div_q == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '1;
      press_q   <= '0;
      state_q   <= S_IDLE;
      div_q     <= '0;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      prev_q    <= prev_d;
      press_q   <= press_d;
      state_q   <= state_d;
      div_q     <= div_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rst_cnt_d = rst_cnt_q;
    enter_rst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p_rst) begin
          state_d   = S_CPURST;
          enter_rst = 1'b1;
        end else if (p_step) begin
          state_d = S_STEP;
        end else if (p_run) begin
          state_d = S_RUN;
          div_d   = '0;
        end
      end
      S_STEP: begin
        if (p_rst) begin
          state_d   = S_CPURST;
          enter_rst = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (p_rst) begin
          state_d   = S_CPURST;
          enter_rst = 1'b1;
        end else if (p_stop) begin
          state_d = S_IDLE;
        end else if (bus.cpu_halt) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        // Sticky: only a CPU reset leaves HALTED, even if cpu_halt drops.
        if (p_rst) begin
          state_d   = S_CPURST;
          enter_rst = 1'b1;
        end
      end
      S_CPURST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_rst) begin
      rst_cnt_d = '0;
    end
    // Clear on CPURST entry wins over a same-cycle step pulse.
    cnt_d = enter_rst ? '0 : cnt_q + CNT_W'(ce);
  end

  // Output logic
  always_comb begin
    ce      = 1'b0;
    cpu_rst = 1'b0;
    case (state_q)
      S_STEP:   ce = 1'b1;
      S_RUN:    ce = div_last & ~bus.cpu_halt & ~p_stop & ~p_rst;
      S_CPURST: cpu_rst = 1'b1;
      default:  ;
    endcase
  end

  assign bus.cpu_ce    = ce;
  assign bus.cpu_reset = cpu_rst;
  assign bus.ucode_cnt = cnt_q;
  assign bus.led_idle  = (state_q == S_IDLE);
  assign bus.led_run   = (state_q == S_RUN);
  assign bus.led_halt  = (state_q == S_HALTED);
  assign bus.led_step  = cnt_q[3:0];
  assign bus.dbg_state = state_q;

endmodule

// File: doc/mic1_exec_ctrl.md
Name: mic1_exec_ctrl

Overview:
- Execution controller on the consuming side of the front-panel command interface.
- Takes debounced button levels (run, stop, step, reset), detects press edges, and drives the MIC-1 datapath:
  - a clock-enable pulse per microinstruction;
  - a synchronous CPU reset pulse.
- Counts executed microinstructions, honours a CPU halt request, and reports state on status LEDs.

Parameters:
RUN_DIV, 4, clk cycles per cpu_ce pulse in RUN; legal range >= 1; 1 = every cycle
RST_CYCLES, 3, number of cycles cpu_reset is held after a reset command; legal range >= 1
CNT_W, 16, width of the microinstruction counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high block reset
btn_run  in  1  debounced level, run command
btn_stop  in  1  debounced level, stop command
btn_step  in  1  debounced level, single-step command
btn_rst  in  1  debounced level, CPU reset command
cpu_halt  in  1  level from MIC-1, high = halt microinstruction reached
cpu_ce  out  1  datapath clock-enable, one microinstruction per high cycle
cpu_reset  out  1  synchronous reset to the MIC-1 datapath
ucode_cnt  out  CNT_W  microinstructions executed since last CPU reset
led_idle  out  1  high in IDLE
led_run  out  1  high in RUN
led_halt  out  1  high in HALTED
led_step  out  4  ucode_cnt[3:0]

Behaviour:
- Edge detect:
  - One prev register per button; press_x = btn_x & ~prev_x.
  - On reset, prev_x are loaded with 1, so a button held through reset produces no press until it is released and pressed again.
- Press priority when several presses occur in one cycle: rst > stop > step > run. Only the highest-priority press is acted on; the others are discarded.
- States: IDLE, RUN, STEP, HALTED, CPURST. State register, div counter, ucode_cnt and rst counter are all registered.
- Block reset (reset=1): state=IDLE, div=0, ucode_cnt=0, rst counter=0, prev=all 1s. Outputs: cpu_ce=0, cpu_reset=0, led_idle=1, led_run=0, led_halt=0.
- IDLE:
  - press_rst -> CPURST
  - press_step -> STEP
  - press_run -> RUN, div=0
  - cpu_ce=0
- STEP:
  - Lasts exactly one cycle; cpu_ce=1 in that cycle; next state IDLE.
  - Latency: step press sampled at edge N -> cpu_ce high for the single cycle after edge N+1.
  - press_rst during STEP -> CPURST (cpu_ce still 1 that cycle).
- RUN:
  - div counts 0..RUN_DIV-1 and wraps.
  - cpu_ce = (div==RUN_DIV-1) & ~cpu_halt & ~press_stop & ~press_rst.
  - Exit priority:
    - press_rst -> CPURST
    - press_stop -> IDLE
    - cpu_halt -> HALTED (no cpu_ce in that cycle)
  - Presses of run and step are ignored.
- HALTED:
  - cpu_ce=0. Only press_rst is accepted (-> CPURST); run, step and stop are ignored.
  - Exit requires a CPU reset even if cpu_halt later falls.
- CPURST:
  - cpu_reset=1 for exactly RST_CYCLES consecutive cycles, then IDLE.
  - ucode_cnt cleared to 0 on entry.
  - All presses ignored, including a repeated rst.
- Reset-mid-operation: block reset overrides every state in the same edge. cpu_reset is not asserted by block reset; the block is held in reset by its own reset input.
- ucode_cnt:
  - Increments by 1 on every cycle with cpu_ce=1.
  - Wraps modulo 2^CNT_W (all-ones -> 0) with no flag.
- Outputs:
  - led_* are pure decodes of state.
  - cpu_ce and cpu_reset are never high in the same cycle.
- cpu_halt sampled in IDLE or STEP has no effect; it is acted on only in RUN.

Test Plan:
- Reset then single step:
  - Stimulus: reset 2 cycles; btn_step high 5 cycles, then low.
  - Required: exactly one cpu_ce pulse, 2 cycles after the rising edge of btn_step; ucode_cnt=1; led_step=4'b0001; led_idle=1 afterwards.
  - Then pulse btn_step again: ucode_cnt=2.
- Run with RUN_DIV=4:
  - Stimulus: btn_run press, hold 40 cycles, then btn_stop press.
  - Required: cpu_ce exactly every 4th cycle (10 pulses in 40 cycles); no cpu_ce in the stop cycle; led_run 1->0, led_idle 0->1.
- Halt:
  - Stimulus: in RUN, assert cpu_halt on a div==RUN_DIV-1 cycle.
  - Required: no cpu_ce that cycle; next state HALTED, led_halt=1.
  - Then btn_step and btn_run presses: no cpu_ce, state unchanged.
  - Then btn_rst press: cpu_reset high for exactly 3 cycles; ucode_cnt=0; state IDLE.
- Simultaneous presses:
  - Stimulus: btn_run and btn_step rise in the same cycle from IDLE.
  - Required: STEP taken, one cpu_ce pulse, no RUN.
  - Stimulus: btn_stop and btn_rst rise together in RUN.
  - Required: CPURST entered, cpu_ce=0 that cycle.
- Held button through reset:
  - Stimulus: btn_run=1 before and during reset, kept high afterwards.
  - Required: state stays IDLE.
  - Then release and re-press: RUN entered.
- Counter wrap with CNT_W=4, RUN_DIV=1:
  - Stimulus: run for 17 cycles.
  - Required: ucode_cnt sequence 0,1,...,15,0,1.
  - Then reset mid-RUN: next cycle IDLE, ucode_cnt=0, cpu_ce=0.
